// File: rtl/core_status.sv
// core_status: 2A03 processor status (P) register.
// Latches ALU flags, applies flag micro-ops, handles PLP/RTI pulls and
// PHP/BRK push formatting, keeps the poll-latched IRQ mask and evaluates
// branch conditions.
// Optional feature: define CORE_STATUS_DECIMAL_EN to store the D flag;
// otherwise D reads as 0 and SED/CLD are no-ops.
module core_status (
  input  logic       I_clock,
  input  logic       I_reset_n,
  input  logic       I_alu_write,
  input  logic       I_alu_carry,
  input  logic       I_alu_overflow,
  input  logic       I_alu_sign,
  input  logic       I_alu_zero,
  input  logic [2:0] I_flag_op,
  input  logic       I_pull,
  input  logic [7:0] I_data,
  input  logic       I_pull_immediate,
  input  logic       I_set_irq_disable,
  input  logic       I_poll,
  input  logic       I_brk_b,
  input  logic [2:0] I_branch_cond,
  output logic       O_carry,
  output logic       O_overflow,
  output logic       O_sign,
  output logic       O_zero,
  output logic       O_decimal,
  output logic       O_irq_disable,
  output logic       O_irq_mask,
  output logic [7:0] O_push_byte,
  output logic       O_branch_taken
);

  localparam logic [2:0] OP_CLC = 3'd1;
  localparam logic [2:0] OP_SEC = 3'd2;
  localparam logic [2:0] OP_CLI = 3'd3;
  localparam logic [2:0] OP_SEI = 3'd4;
  localparam logic [2:0] OP_CLV = 3'd5;
  localparam logic [2:0] OP_CLD = 3'd6;
  localparam logic [2:0] OP_SED = 3'd7;

  logic c_q, z_q, i_q, v_q, n_q, mask_q;
  logic c_d, z_d, i_d, v_d, n_d, mask_d;
  logic dec_flag;

  // Bits 5 and 4 of a pulled byte have no storage.
  logic unused_data_bits;
  assign unused_data_bits = ^I_data[5:4];

  // An op that targets a flag being written by a pull or the ALU loses.
  logic cvz_busy;
  logic id_busy;
  assign cvz_busy = I_pull | I_alu_write;
  assign id_busy  = I_pull;

  // Next-state for the C/Z/I/V/N flags and the IRQ mask.
  always_comb begin
    c_d    = c_q;
    z_d    = z_q;
    i_d    = i_q;
    v_d    = v_q;
    n_d    = n_q;
    mask_d = mask_q;

    if (I_pull) begin
      c_d = I_data[0];
      z_d = I_data[1];
      i_d = I_data[2];
      v_d = I_data[6];
      n_d = I_data[7];
    end else if (I_alu_write) begin
      c_d = I_alu_carry;
      z_d = I_alu_zero;
      v_d = I_alu_overflow;
      n_d = I_alu_sign;
    end

    case (I_flag_op)
      OP_CLC:  if (!cvz_busy) c_d = 1'b0;
      OP_SEC:  if (!cvz_busy) c_d = 1'b1;
      OP_CLV:  if (!cvz_busy) v_d = 1'b0;
      OP_CLI:  if (!id_busy)  i_d = 1'b0;
      OP_SEI:  if (!id_busy)  i_d = 1'b1;
      default: ;
    endcase

    // Interrupt entry always wins for I, even over a pull.
    i_d = i_d | I_set_irq_disable;

    // Poll samples the pre-update I, so CLI/SEI/PLP take effect one
    // instruction late; RTI bypasses that; interrupt entry masks at once.
    if (I_poll)
      mask_d = i_q;
    if (I_pull && I_pull_immediate)
      mask_d = I_data[2];
    if (I_set_irq_disable)
      mask_d = 1'b1;
  end

  // Flag and mask registers with synchronous active-low reset.
  always_ff @(posedge I_clock) begin
    if (!I_reset_n) begin
      c_q    <= 1'b0;
      z_q    <= 1'b0;
      i_q    <= 1'b1;
      v_q    <= 1'b0;
      n_q    <= 1'b0;
      mask_q <= 1'b1;
    end else begin
      c_q    <= c_d;
      z_q    <= z_d;
      i_q    <= i_d;
      v_q    <= v_d;
      n_q    <= n_d;
      mask_q <= mask_d;
    end
  end

`ifdef CORE_STATUS_DECIMAL_EN
  logic d_q, d_d;

  // Next-state for D: pull loads it, SED/CLD change it when no pull.
  always_comb begin
    d_d = d_q;
    if (I_pull)
      d_d = I_data[3];
    else if (I_flag_op == OP_SED)
      d_d = 1'b1;
    else if (I_flag_op == OP_CLD)
      d_d = 1'b0;
  end

  // D register with synchronous active-low reset.
  always_ff @(posedge I_clock) begin
    if (!I_reset_n)
      d_q <= 1'b0;
    else
      d_q <= d_d;
  end

  assign dec_flag = d_q;
`else
  // Without decimal storage the pulled D bit is discarded.
  logic unused_decimal_bit;
  assign unused_decimal_bit = I_data[3];
  assign dec_flag = 1'b0;
`endif

  assign O_carry       = c_q;
  assign O_zero        = z_q;
  assign O_overflow    = v_q;
  assign O_sign        = n_q;
  assign O_decimal     = dec_flag;
  assign O_irq_disable = i_q;
  assign O_irq_mask    = mask_q;

  // Push byte reflects registered flags only (NV1B DIZC).
  assign O_push_byte = {n_q, v_q, 1'b1, I_brk_b, dec_flag, i_q, z_q, c_q};

  // Branch condition: [2:1] picks N/V/C/Z, [0] is the value required.
  always_comb begin
    logic sel_flag;
    sel_flag = n_q;
    case (I_branch_cond[2:1])
      2'b00: sel_flag = n_q;
      2'b01: sel_flag = v_q;
      2'b10: sel_flag = c_q;
      2'b11: sel_flag = z_q;
      default: sel_flag = n_q;
    endcase
    O_branch_taken = (sel_flag == I_branch_cond[0]);
  end

endmodule

// File: tb/tb_core_status.sv
// tb_core_status: directed, table-driven bench for core_status.
// Each vector is applied for one clock; registered outputs are checked
// 1 time unit after the rising edge while the vector's inputs are held.
module tb_core_status;

  logic       clk;
  logic       reset_n;
  logic       alu_write;
  logic       alu_carry, alu_overflow, alu_sign, alu_zero;
  logic [2:0] flag_op;
  logic       pull;
  logic [7:0] data;
  logic       pull_immediate;
  logic       set_irq_disable;
  logic       poll;
  logic       brk_b;
  logic [2:0] branch_cond;
  logic       carry, overflow, sign, zero, decimal, irq_disable, irq_mask;
  logic [7:0] push_byte;
  logic       branch_taken;

  int checks;
  int fails;

`ifdef CORE_STATUS_DECIMAL_EN
  localparam logic [7:0] D_MASK = 8'hFF;
`else
  localparam logic [7:0] D_MASK = 8'hF7;
`endif

  core_status dut (
    .I_clock          (clk),
    .I_reset_n        (reset_n),
    .I_alu_write      (alu_write),
    .I_alu_carry      (alu_carry),
    .I_alu_overflow   (alu_overflow),
    .I_alu_sign       (alu_sign),
    .I_alu_zero       (alu_zero),
    .I_flag_op        (flag_op),
    .I_pull           (pull),
    .I_data           (data),
    .I_pull_immediate (pull_immediate),
    .I_set_irq_disable(set_irq_disable),
    .I_poll           (poll),
    .I_brk_b          (brk_b),
    .I_branch_cond    (branch_cond),
    .O_carry          (carry),
    .O_overflow       (overflow),
    .O_sign           (sign),
    .O_zero           (zero),
    .O_decimal        (decimal),
    .O_irq_disable    (irq_disable),
    .O_irq_mask       (irq_mask),
    .O_push_byte      (push_byte),
    .O_branch_taken   (branch_taken)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       alu_wr;
    logic [3:0] alu;      // {c, v, n, z}
    logic [2:0] op;
    logic       pull;
    logic [7:0] data;
    logic       imm;
    logic       seti;
    logic       poll;
    logic       brk;
    logic [2:0] cond;
    logic [7:0] exp_push; // value with D stored; D_MASK applied at check
    logic       exp_mask;
    logic       exp_taken;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst_n, input logic alu_wr, input logic [3:0] alu,
                     input logic [2:0] op, input logic pl, input logic [7:0] d,
                     input logic imm, input logic seti, input logic pol,
                     input logic brk, input logic [2:0] cond,
                     input logic [7:0] ep, input logic em, input logic et);
    vec_t v;
    v.rst_n = rst_n; v.alu_wr = alu_wr; v.alu = alu; v.op = op;
    v.pull = pl; v.data = d; v.imm = imm; v.seti = seti; v.poll = pol;
    v.brk = brk; v.cond = cond; v.exp_push = ep; v.exp_mask = em;
    v.exp_taken = et;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    reset_n = v.rst_n;
    alu_write = v.alu_wr;
    {alu_carry, alu_overflow, alu_sign, alu_zero} = v.alu;
    flag_op = v.op;
    pull = v.pull;
    data = v.data;
    pull_immediate = v.imm;
    set_irq_disable = v.seti;
    poll = v.poll;
    brk_b = v.brk;
    branch_cond = v.cond;
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Scoreboard check of all outputs against one vector's expectations.
  task automatic check_vec(input int idx, input vec_t v);
    logic [7:0] ep;
    ep = v.exp_push & D_MASK;
    check8($sformatf("v%0d push_byte", idx), push_byte, ep);
    check8($sformatf("v%0d flags", idx),
           {2'b00, sign, overflow, decimal, irq_disable, zero, carry},
           {2'b00, ep[7], ep[6], ep[3], ep[2], ep[1], ep[0]});
    check8($sformatf("v%0d irq_mask", idx), {7'd0, irq_mask}, {7'd0, v.exp_mask});
    check8($sformatf("v%0d branch_taken", idx), {7'd0, branch_taken}, {7'd0, v.exp_taken});
  endtask

  initial begin
    checks = 0;
    fails  = 0;

    // rst alu_wr alu(cvnz) op pull data imm seti poll brk cond  push  mask taken
    add(0, 0, 4'b0000, 3'd0, 0, 8'h00, 0, 0, 0, 1, 3'b000, 8'h34, 1, 1); // 0 reset
    add(0, 0, 4'b0000, 3'd0, 0, 8'h00, 0, 0, 0, 1, 3'b000, 8'h34, 1, 1); // 1 reset
    add(1, 0, 4'b0000, 3'd0, 0, 8'h00, 0, 0, 0, 1, 3'b000, 8'h34, 1, 1); // 2 idle
    add(1, 0, 4'b0000, 3'd3, 0, 8'h00, 0, 0, 1, 1, 3'b000, 8'h30, 1, 1); // 3 CLI+poll: old I
    add(1, 0, 4'b0000, 3'd0, 0, 8'h00, 0, 0, 0, 1, 3'b000, 8'h30, 1, 1); // 4
    add(1, 0, 4'b0000, 3'd0, 0, 8'h00, 0, 0, 0, 1, 3'b000, 8'h30, 1, 1); // 5
    add(1, 0, 4'b0000, 3'd0, 0, 8'h00, 0, 0, 1, 1, 3'b000, 8'h30, 0, 1); // 6 poll -> mask 0
    add(1, 1, 4'b1101, 3'd1, 0, 8'h00, 0, 0, 0, 0, 3'b111, 8'h63, 0, 1); // 7 ALU + CLC ignored, BEQ
    add(1, 0, 4'b0000, 3'd0, 0, 8'h00, 0, 0, 0, 1, 3'b110, 8'h73, 0, 0); // 8 BNE not taken
    add(1, 1, 4'b0010, 3'd2, 0, 8'h00, 0, 0, 0, 1, 3'b001, 8'hB0, 0, 1); // 9 ALU + SEC ignored, BMI
    add(1, 1, 4'b1111, 3'd4, 0, 8'h00, 0, 0, 0, 1, 3'b011, 8'hF7, 0, 1); // 10 SEI applies with ALU, BVS
    add(1, 0, 4'b0000, 3'd5, 0, 8'h00, 0, 0, 0, 1, 3'b010, 8'hB7, 0, 1); // 11 CLV, BVC
    add(1, 0, 4'b0000, 3'd0, 0, 8'h00, 0, 0, 1, 1, 3'b100, 8'hB7, 1, 0); // 12 poll -> mask 1, BCC
    add(1, 1, 4'b0000, 3'd1, 1, 8'hFF, 0, 0, 0, 1, 3'b101, 8'hFF, 1, 1); // 13 pull beats ALU/CLC, BCS
    add(1, 0, 4'b0000, 3'd6, 0, 8'h00, 0, 0, 0, 1, 3'b000, 8'hF7, 1, 0); // 14 CLD
    add(1, 0, 4'b0000, 3'd7, 0, 8'h00, 0, 0, 0, 1, 3'b000, 8'hFF, 1, 0); // 15 SED
    add(1, 0, 4'b0000, 3'd0, 1, 8'h00, 1, 0, 1, 1, 3'b111, 8'h30, 0, 0); // 16 RTI imm beats poll
    add(1, 0, 4'b0000, 3'd0, 1, 8'h00, 1, 1, 0, 1, 3'b110, 8'h34, 1, 1); // 17 RTI + irq entry
    add(1, 0, 4'b0000, 3'd0, 1, 8'hC3, 0, 0, 1, 1, 3'b111, 8'hF3, 1, 1); // 18 PLP + poll: old I
    add(1, 0, 4'b0000, 3'd0, 0, 8'h00, 0, 0, 1, 1, 3'b111, 8'hF3, 0, 1); // 19 poll -> mask 0
    add(1, 0, 4'b0000, 3'd4, 1, 8'h08, 0, 0, 0, 1, 3'b110, 8'h38, 0, 1); // 20 SEI ignored under pull
    add(1, 0, 4'b0000, 3'd2, 0, 8'h00, 0, 1, 0, 1, 3'b100, 8'h3D, 1, 0); // 21 SEC + irq entry
    add(0, 1, 4'b0001, 3'd0, 1, 8'hFF, 0, 0, 0, 1, 3'b110, 8'h34, 1, 1); // 22 reset beats pull/ALU

    drive(vecs[0]);
    foreach (vecs[k]) begin
      drive(vecs[k]);
      @(posedge clk);
      #1;
      check_vec(k, vecs[k]);
    end

    // Branch result is combinational: sweep conditions with no clock edge.
    // State here: N=V=C=Z=0, so taken == ~cond[0].
    for (int cnd = 0; cnd < 8; cnd++) begin
      branch_cond = cnd[2:0];
      #1;
      check8($sformatf("comb branch cond=%0d", cnd), {7'd0, branch_taken},
             {7'd0, ~cnd[0]});
    end

    // Push byte B bit follows I_brk_b combinationally, no forwarding of
    // a same-cycle ALU write before the edge.
    reset_n = 1'b1; alu_write = 1'b1;
    {alu_carry, alu_overflow, alu_sign, alu_zero} = 4'b1111;
    brk_b = 1'b0;
    #1;
    check8("push pre-edge", push_byte, 8'h24);
    @(posedge clk);
    #1;
    check8("push post-edge", push_byte, 8'hE7);
    alu_write = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
